uart_fifo_ctl: RTL and testbench

Parametrised synchronous FIFO for the UART TX/RX data paths, succeeding the simple fixed-size FIFO. Adds arbitrary (non power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and well-defined simultaneous read/write at the full and empty boundaries. It sits between the UART byte engines and the host-side register interface.

---
 rtl/uart_fifo_ctl.sv | 96 +++++++++
 tb/tb_uart_fifo_ctl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctl.sv
// Parametrised synchronous FIFO for the UART data paths: arbitrary depth, occupancy
// count, programmable almost thresholds, sticky overflow/underflow error flags.
module uart_fifo_ctl #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         write_mode,
  input  logic                         read_mode,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         clear_errors,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [CW-1:0]         count_next;

  // Accept decisions come from registered state; a read frees a slot for a write when full.
  always_comb begin
    rd_ok      = read_mode && !empty;
    wr_ok      = write_mode && (!full || rd_ok);
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = count + 1'b1;
    else if (rd_ok && !wr_ok)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset && enable && wr_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      data_out     <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clear_errors) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (enable) begin
        // Placed after the clear so a same-cycle error keeps the flag set.
        if (write_mode && !wr_ok) overflow  <= 1'b1;
        if (read_mode && !rd_ok)  underflow <= 1'b1;
        if (rd_ok) begin
          data_out <= mem[rd_ptr];
          valid    <= 1'b1;
          rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        end
        if (wr_ok)
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        count        <= count_next;
        empty        <= (count_next == '0);
        full         <= (count_next == DEPTH_C);
        almost_empty <= (count_next <= AE_C);
        almost_full  <= (count_next >= AF_C);
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Bench for uart_fifo_ctl (DEPTH=6, AF=5, AE=1): directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_uart_fifo_ctl;

  localparam int DEPTH = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0, enable = 1'b1, write_mode = 1'b0, read_mode = 1'b0, clear_errors = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_valid, m_ovf, m_udf;
  logic [6:0] flags_act;

  assign flags_act = {full, empty, almost_full, almost_empty, overflow, underflow, valid};

  uart_fifo_ctl #(.DEPTH(6), .DATA_WIDTH(8), .AF_LEVEL(5), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .write_mode(write_mode),
    .read_mode(read_mode), .data_in(data_in), .clear_errors(clear_errors),
    .data_out(data_out), .valid(valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mflags();
    int n = q.size();
    return {n == DEPTH, n == 0, n >= 5, n <= 1, m_ovf, m_udf, m_valid};
  endfunction

  function automatic void model_step(logic we, logic re, logic [7:0] din,
                                     logic en, logic clr, logic rst);
    bit rd, wr;
    if (rst) begin
      q.delete();
      m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
      return;
    end
    m_valid = 0;
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (!en) return;
    rd = re && q.size() > 0;
    wr = we && (q.size() < DEPTH || rd);
    if (we && !wr) m_ovf = 1;
    if (re && !rd) m_udf = 1;
    if (rd) begin m_dout = q.pop_front(); m_valid = 1; end
    if (wr) q.push_back(din);
  endfunction

  task automatic cyc(input logic we, input logic re, input logic [7:0] din,
                     input logic en = 1'b1, input logic clr = 1'b0, input logic rst = 1'b0);
    write_mode = we; read_mode = re; data_in = din;
    enable = en; clear_errors = clr; reset = rst;
    @(posedge clk);
    model_step(we, re, din, en, clr, rst);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 8'hFF, 1, 0, 1);
    cyc(1, 1, 8'hFF, 0, 0, 1);
    cyc(0, 0, 8'h00);
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (flags_act !== 7'b0101000) begin
      errors++; $display("FAIL reset_flags got %b want 0101000", flags_act);
    end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", data_out); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 8'(8'h11 * (i + 1)));
      checks++;
      if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      checks++;
      if (flags_act !== mflags()) begin
        errors++; $display("FAIL fill_flags[%0d] got %b want %b", i, flags_act, mflags());
      end
    end
    cyc(1, 0, 8'h77);
    checks++;
    if (count !== 3'd6 || overflow !== 1'b1 || full !== 1'b1) begin
      errors++; $display("FAIL overflow_write got count=%0d ovf=%b full=%b want 6 1 1", count, overflow, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 8'h00);
      checks++;
      if (data_out !== 8'(8'h11 * (i + 1)) || valid !== 1'b1) begin
        errors++; $display("FAIL drain[%0d] got %h/%b want %h/1", i, data_out, valid, 8'(8'h11 * (i + 1)));
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got %b/%0d want 1/0", empty, count); end
    cyc(0, 1, 8'h00);
    checks++;
    if (valid !== 1'b0 || underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_read got valid=%b udf=%b want 0 1", valid, underflow);
    end
    cyc(0, 0, 8'h00, 1, 1);
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL clear_errors got %b%b want 00", overflow, underflow);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'(8'h11 * (i + 1)));
    cyc(1, 1, 8'hA0);
    checks++;
    if (data_out !== 8'h11 || count !== 3'd6 || overflow !== 1'b0 || valid !== 1'b1) begin
      errors++; $display("FAIL full_rw got dout=%h count=%0d ovf=%b valid=%b want 11 6 0 1", data_out, count, overflow, valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 8'h00);
      checks++;
      if (data_out !== m_dout) begin errors++; $display("FAIL full_rw_drain[%0d] got %h want %h", i, data_out, m_dout); end
    end
    checks++;
    if (data_out !== 8'hA0 || empty !== 1'b1) begin
      errors++; $display("FAIL full_rw_last got %h/%b want a0/1", data_out, empty);
    end
  endtask

  task automatic test_empty_rw();
    cyc(1, 1, 8'h5A);
    checks++;
    if (count !== 3'd1 || valid !== 1'b0 || underflow !== 1'b1) begin
      errors++; $display("FAIL empty_rw got count=%0d valid=%b udf=%b want 1 0 1", count, valid, underflow);
    end
    cyc(0, 1, 8'h00);
    checks++;
    if (data_out !== 8'h5A || valid !== 1'b1) begin
      errors++; $display("FAIL empty_rw_read got %h/%b want 5a/1", data_out, valid);
    end
    cyc(0, 0, 8'h00, 1, 1);
  endtask

  task automatic test_enable_reset();
    logic [7:0] held;
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'($urandom));
    held = data_out;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 8'hEE, 0);
      checks++;
      if (count !== 3'd3 || data_out !== held || flags_act !== mflags() || valid !== 1'b0) begin
        errors++; $display("FAIL enable_low[%0d] got count=%0d dout=%h flags=%b want 3 %h %b", i, count, data_out, flags_act, held, mflags());
      end
    end
    cyc(0, 0, 8'h00, 1, 0, 1);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL mid_reset got count=%0d empty=%b want 0 1", count, empty);
    end
  endtask

  task automatic test_random();
    int wp;
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 40) % 2 == 0) ? 80 : 25;
      cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp, 8'($urandom),
          $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
      checks++;
      if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", i, count, q.size()); end
      checks++;
      if (flags_act !== mflags()) begin errors++; $display("FAIL rand_flags[%0d] got %b want %b", i, flags_act, mflags()); end
      checks++;
      if (data_out !== m_dout) begin errors++; $display("FAIL rand_dout[%0d] got %h want %h", i, data_out, m_dout); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_enable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
